if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage that produces the PC / instruction / bubble triple consumed by the IF/ID pipeline register. It owns the PC, drives the instruction-memory address, and honours the hazard unit's stall. Branch handling is stall-based (no prediction): after issuing any control-transfer instruction it emits NOPs until EX resolves the branch, then redirects. It also detects misaligned targets and keeps a bubble performance counter.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000013, encoding driven on idata_out during bubbles (addi x0,x0,0).
CNT_W, 16, width of bubble_cnt.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low: 0 = reset asserted.
stall  in  1  hazard-unit stall; the IF/ID register holds while high.
iaddr  out  32  instruction-memory address, always equal to the PC register.
idata_in  in  32  instruction from imem, valid in the same cycle as iaddr.
resolve_valid  in  1  EX-stage branch resolution strobe.
resolve_taken  in  1  1 = redirect to resolve_target; qualified by resolve_valid.
resolve_target  in  32  redirect address; qualified by resolve_valid & resolve_taken.
PC_curr_out  out  32  PC of the instruction on idata_out, to IF/ID PC_curr_in.
idata_out  out  32  instruction to IF/ID idata_in.
is_nop_out  out  1  1 = idata_out is a bubble, to IF/ID is_nop_in.
misalign_err  out  1  sticky; set on a taken redirect with resolve_target[1:0] != 0.
bubble_cnt  out  CNT_W  saturating count of cycles with is_nop_out=1 while reset is deasserted.

Behaviour:
- State: pc[31:0]; FSM {RUN, WAIT, HALT}; misalign_err; bubble_cnt.
- Async reset (reset=0): pc=RESET_PC, state=RUN, misalign_err=0, bubble_cnt=0. Applies immediately, including mid-WAIT or HALT.
- While reset=0, outputs are forced: is_nop_out=1, idata_out=NOP_INSTR, PC_curr_out=iaddr=RESET_PC.
- Outputs are combinational from the registered state: iaddr=pc and PC_curr_out=pc.
  - In RUN: idata_out=idata_in, is_nop_out=0.
  - In WAIT or HALT: idata_out=NOP_INSTR, is_nop_out=1.
- Control-transfer predecode: ctrl = idata_in[6:0] is 7'b1100011 (BRANCH), 7'b1101111 (JAL) or 7'b1100111 (JALR).
- RUN, stall=1: pc and state hold. Zero-cycle stall latency, so the same instruction is re-presented.
- RUN, stall=0, ctrl=0: pc <= pc+4 (mod 2^32).
- RUN, stall=0, ctrl=1: pc <= pc+4 and state <= WAIT. The control instruction itself is emitted this cycle with is_nop_out=0.
- RUN, resolve_valid=1: protocol violation, ignored. RUN-state transitions take priority.
- WAIT, resolve_valid=0: pc holds and NOPs are emitted, regardless of stall.
- WAIT, resolve_valid=1: accepted regardless of stall. The output in the resolving cycle is still a NOP.
  - resolve_taken=0: pc holds (already branch PC+4), state <= RUN.
  - resolve_taken=1, target[1:0]=0: pc <= resolve_target, state <= RUN.
  - resolve_taken=1, target[1:0]!=0: pc holds, misalign_err <= 1, state <= HALT.
- HALT: absorbing state. Emits NOPs until reset; all inputs are ignored.
- Minimum branch penalty: one NOP cycle (resolve in the first WAIT cycle). The first target instruction appears the cycle after resolve_valid.
- bubble_cnt increments on each clock edge where reset=1 and is_nop_out=1, saturating at all-ones. Stalled RUN cycles are not counted.
- pc+4 wraps from 32'hFFFFFFFC to 0 with no flag.

Test Plan:
- Reset and sequential fetch: release reset with RESET_PC=0 and non-control idata_in for 4 cycles, stall=0 -> PC_curr_out = 0,4,8,12; is_nop_out=0; bubble_cnt=0.
- Stall hold: at pc=8 assert stall for 3 cycles -> iaddr and PC_curr_out stay 8, is_nop_out=0; after deassert, the next PC is 12.
- Taken branch: idata_in=32'h00000063 at pc=0x10 -> emitted with is_nop_out=0. Then 3 NOP cycles with PC_curr_out=0x14. Resolve taken with target 0x40 in the 3rd NOP cycle -> next cycle PC_curr_out=0x40 with is_nop_out=0; bubble_cnt=3.
- Not-taken JAL/JALR path: JALR at pc=0x20, resolve_taken=0 in the first WAIT cycle -> one NOP, then PC_curr_out=0x24. Resolve while stall=1 -> still accepted.
- Misaligned target: resolve taken with target 0x42 -> misalign_err=1, is_nop_out=1 indefinitely, pc frozen. Async reset pulse between clock edges -> immediate RESET_PC, misalign_err=0, state RUN.
- Saturation and wrap: with CNT_W=2, force 5 NOP cycles -> bubble_cnt=3. Preload to pc=32'hFFFFFFFC via redirect -> next PC is 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents PC/instruction/bubble to IF/ID,
// holds on stall and inserts NOPs after any control transfer until EX resolves it.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    output logic [31:0]      iaddr,
    input  logic [31:0]      idata_in,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  logic [31:0]      resolve_target,
    output logic [31:0]      PC_curr_out,
    output logic [31:0]      idata_out,
    output logic             is_nop_out,
    output logic             misalign_err,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ctrl;
    logic               bubble;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    // Counted edges always have reset high, so bubble equals is_nop_out there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        ctrl = (idata_in[6:0] == OP_BRANCH) || (idata_in[6:0] == OP_JAL) ||
               (idata_in[6:0] == OP_JALR);
    end

    // resolve_valid is a one-cycle strobe with no ready: it is consumed only
    // in WAIT (stall does not block it) and ignored in RUN and HALT.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        unique case (state_q)
            RUN: begin
                if (!stall) begin
                    pc_d = pc_q + 32'd4;
                    if (ctrl) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (resolve_valid) begin
                    if (!resolve_taken) begin
                        state_d = RUN;
                    end else if (resolve_target[1:0] == 2'b00) begin
                        pc_d    = resolve_target;
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_comb begin
        bubble       = (state_q != RUN);
        iaddr        = reset ? pc_q : RESET_PC;
        PC_curr_out  = reset ? pc_q : RESET_PC;
        is_nop_out   = !reset || bubble;
        idata_out    = is_nop_out ? NOP_INSTR : idata_in;
        misalign_err = err_q;
        bubble_cnt   = cnt_q;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random traffic against a
// cycle-level reference model; a second instance with CNT_W=2 checks saturation.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] idata_in;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;

    logic [31:0] iaddr, pc_curr, idata_out;
    logic        is_nop, merr;
    logic [15:0] bcnt;
    logic [1:0]  dstate;

    logic [31:0] iaddr2, pc_curr2, idata_out2;
    logic        is_nop2, merr2;
    logic [1:0]  bcnt2;
    logic [1:0]  dstate2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    int          m_mode;   // 0 fetching, 1 waiting for resolve, 2 halted
    logic        m_err;
    int          m_cnt;
    logic [31:0] exp_pc, exp_idata;
    logic        exp_nop;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .iaddr(iaddr), .idata_in(idata_in),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .PC_curr_out(pc_curr), .idata_out(idata_out),
        .is_nop_out(is_nop), .misalign_err(merr), .bubble_cnt(bcnt), .dbg_state(dstate)
    );

    if_fetch_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .iaddr(iaddr2), .idata_in(idata_in),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .PC_curr_out(pc_curr2), .idata_out(idata_out2),
        .is_nop_out(is_nop2), .misalign_err(merr2), .bubble_cnt(bcnt2), .dbg_state(dstate2)
    );

    function automatic logic is_ctrl_op(input logic [6:0] op);
        return (op == 7'h63) || (op == 7'h6F) || (op == 7'h67);
    endfunction

    function automatic logic [31:0] rand_plain();
        logic [6:0] ops [5];
        ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b0110111;
        return {$urandom_range(0, 32'h01FF_FFFF), 7'h00} | 32'(ops[$urandom_range(0, 4)]);
    endfunction

    function automatic logic [31:0] rand_ctrl();
        logic [6:0] ops [3];
        ops[0] = 7'b1100011; ops[1] = 7'b1101111; ops[2] = 7'b1100111;
        return {$urandom_range(0, 32'h01FF_FFFF), 7'h00} | 32'(ops[$urandom_range(0, 2)]);
    endfunction

    function automatic logic [115:0] obs_vec();
        return {iaddr, pc_curr, idata_out, is_nop, merr, bcnt, bcnt2};
    endfunction

    function automatic logic [115:0] exp_vec();
        logic [15:0] c16;
        logic [1:0]  c2;
        c16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        c2  = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
        return {exp_pc, exp_pc, exp_idata, exp_nop, m_err, c16, c2};
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0;
        m_mode = 0;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic drive(input logic s, input logic [31:0] d, input logic rv,
                         input logic rt, input logic [31:0] tgt);
        stall          = s;
        idata_in       = d;
        resolve_valid  = rv;
        resolve_taken  = rt;
        resolve_target = tgt;
        #2;
        exp_nop   = !reset || (m_mode != 0);
        exp_idata = exp_nop ? NOP : d;
        exp_pc    = reset ? m_pc : 32'h0;
    endtask

    // Applies one clock edge to the model using the currently driven inputs.
    task automatic advance();
        if (m_mode != 0) m_cnt++;
        if (m_mode == 0) begin
            if (!stall) begin
                m_pc = m_pc + 32'd4;
                if (is_ctrl_op(idata_in[6:0])) m_mode = 1;
            end
        end else if (m_mode == 1 && resolve_valid) begin
            if (!resolve_taken) begin
                m_mode = 0;
            end else if (resolve_target % 4 == 0) begin
                m_pc   = resolve_target;
                m_mode = 0;
            end else begin
                m_err  = 1'b1;
                m_mode = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom_range(0, 1)), rand_ctrl(), 1'b1, 1'b1, 32'h42);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_forced %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, rand_plain(), 1'($urandom_range(0, 1)), 1'b1, $urandom);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL seq_fetch %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, (i == 1) ? rand_ctrl() : rand_plain(), 1'b0, 1'b0, 32'h0);
            else       drive(1'b0, rand_plain(), 1'b0, 1'b0, 32'h0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stall_hold %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_taken_branch();
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      drive(1'b0, 32'h0000_0063, 1'b0, 1'b0, 32'h0);
            else if (i < 4)  drive(1'($urandom_range(0, 1)), rand_ctrl(), (i == 3), 1'b1, 32'h40);
            else             drive(1'b0, rand_plain(), 1'b0, 1'b0, 32'h0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL taken_branch %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_not_taken();
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      drive(1'b0, 32'h0000_8067, 1'b0, 1'b0, 32'h0);
            else if (i == 1) drive(1'b1, rand_plain(), 1'b1, 1'b0, 32'h80);
            else             drive(1'b0, rand_plain(), 1'b0, 1'b0, 32'h0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL not_taken %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      drive(1'b0, 32'h0000_006F, 1'b0, 1'b0, 32'h0);
            else if (i == 1) drive(1'b0, rand_plain(), 1'b1, 1'b1, 32'hFFFF_FFFC);
            else             drive(1'b0, rand_plain(), 1'b0, 1'b0, 32'h0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL pc_wrap %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_misalign();
        for (int i = 0; i < 9; i++) begin
            if (i == 0)      drive(1'b0, rand_ctrl(), 1'b0, 1'b0, 32'h0);
            else if (i == 1) drive(1'b0, rand_plain(), 1'b1, 1'b1, 32'h42);
            else             drive(1'($urandom_range(0, 1)), rand_ctrl(), 1'b1,
                                   1'($urandom_range(0, 1)), 32'h100);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL misalign %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            advance();
        end
        // Asynchronous reset pulse landing between clock edges.
        #2;
        reset = 1'b0;
        model_reset();
        drive(1'b0, rand_ctrl(), 1'b1, 1'b1, 32'h42);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
        end
        reset = 1'b1;
        drive(1'b0, rand_plain(), 1'b0, 1'b0, 32'h0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL after_async_reset: got %h want %h", obs_vec(), exp_vec());
        end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                reset = 1'b1;
            end
            tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            drive(($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0) ? rand_ctrl() : rand_plain(),
                  ($urandom_range(0, 4) < 2), 1'($urandom_range(0, 1)), tgt);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        reset          = 1'b0;
        stall          = 1'b0;
        idata_in       = 32'h0;
        resolve_valid  = 1'b0;
        resolve_taken  = 1'b0;
        resolve_target = 32'h0;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_taken_branch();
        test_not_taken();
        test_wrap();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
